apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Multi-requester APB master that shares one APB slave (the 16-entry APB memory slave) between N_REQ internal requesters. Arbitrates round-robin, latches the winning request, drives the APB SETUP/ACCESS sequence, honours p_ready wait states and p_slverr, and returns read data/status to the winning requester. It sits between the internal requesters and the slave's APB port.

## Interface
- A_WIDTH, 8, APB address width
- D_WIDTH, 8, APB data width
- N_REQ, 4, number of requesters (≥2)
- TIMEOUT, 16, max ACCESS cycles without p_ready before forced error termination; 0 disables the timeout

- p_clk  in  1  clock
- p_rstn  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester transfer request, level
- req_write  in  N_REQ  per-requester direction, 1 = write
- req_addr  in  N_REQ*A_WIDTH  per-requester address, requester i at bits [i*A_WIDTH +: A_WIDTH]
- req_wdata  in  N_REQ*D_WIDTH  per-requester write data, same packing
- gnt  out  N_REQ  one-hot, one-cycle acceptance pulse
- rsp_valid  out  N_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  D_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  slave error or timeout, valid with rsp_valid
- busy  out  1  high in SETUP and ACCESS
- p_sel, p_enable, p_write  out  1 each  APB control
- p_addr  out  A_WIDTH;  p_wdata  out  D_WIDTH  APB address and write data
- p_rdata  in  D_WIDTH;  p_ready, p_slverr  in  1 each  APB slave response

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration point: IDLE, or ACCESS in the cycle p_ready=1 (or timeout fires). At an arbitration point with any req high, gnt[winner] is asserted combinationally in that cycle; winner's write/addr/wdata are latched; next state is SETUP. With no req: IDLE.
- Round-robin: search starts at last_grant+1 mod N_REQ. last_grant resets to N_REQ-1, so requester 0 has first priority.
- A requester must drop req, or present its next transfer, in the cycle after gnt. Fields are ignored after the latch.
- SETUP: p_sel=1, p_enable=0, p_addr/p_write/p_wdata from the latch. Always goes to ACCESS next cycle.
- ACCESS: p_sel=1, p_enable=1, fields held stable.
  - p_ready=0: stay; timeout counter increments.
  - p_ready=1: transfer completes.
- Completion, registered and seen the next cycle:
  - rsp_valid[owner]=1
  - rsp_rdata = p_rdata on a read, 0 on a write
  - rsp_err = p_slverr
- Timeout: TIMEOUT consecutive ACCESS cycles with p_ready=0 terminate the transfer.
  - rsp_err=1, rsp_rdata=0; p_sel/p_enable drop unless a new grant goes to SETUP.
- Outside SETUP/ACCESS: p_sel=p_enable=0; p_addr/p_write/p_wdata hold their last values.

## Timing
- Reset (async assert, sync release): every output 0, state IDLE, latch 0, counter 0. Reset mid-transfer aborts it with no rsp_valid.
- Zero wait states: req high at cycle 0 (IDLE) → gnt at 0, SETUP at 1, ACCESS at 2 (p_ready=1) → rsp_valid at 3.
- Back-to-back: a pending req is granted in the completing ACCESS cycle; next cycle is SETUP. Sustained throughput is one transfer per 2 cycles.
- Each wait state adds exactly 1 cycle.
- Timeout counter: $clog2(TIMEOUT+1) bits, cleared on entry to SETUP. Saturating compare: termination occurs in the TIMEOUT-th ACCESS cycle.
- p_ready=1 in the same cycle as the timeout compare counts as normal completion (p_slverr sampled).
- The same requester may hold a pending req while its own transfer completes; it re-competes at the arbitration point under round-robin order.

## Structure
- apb_pkg: state enum (IDLE, SETUP, ACCESS) and default A_WIDTH/D_WIDTH constants, shared with the APB slave and bench.
- Sub-module rr_arbiter #(N_REQ): combinational one-hot pick from req and last_grant; last_grant register updated on grant enable.
- FSM, request latch, timeout counter and response registers live in apb_req_arbiter.

## Test plan
- Single write then read: req0 write addr 3 data 0xA5, p_ready tied 1 → APB sequence SETUP/ACCESS; read of addr 3 returns rsp_rdata=0xA5, rsp_err=0, rsp_valid[0] at cycle 3.
- All four requesters request in the same cycle → grants in order 0,1,2,3. Then req1 and req3 persist → 1,3,1,3 alternation, one transfer per 2 cycles.
- Wait states: slave holds p_ready=0 for 3 ACCESS cycles → p_enable high 4 cycles, APB fields stable, rsp_valid 1 cycle after p_ready.
- Slave error: p_slverr=1 with p_ready on a read → rsp_err=1, rsp_rdata=0 (write) or p_rdata (read), next grant proceeds.
- Timeout: p_ready stuck 0, TIMEOUT=16 → rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles; p_sel drops.
- Async reset asserted during ACCESS → all outputs 0 immediately, no rsp_valid. After release, req2 alone is granted first.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: APB transfer FSM states and default bus widths, shared by the
// arbiter, the APB memory slave and the bench.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
    localparam int APB_AW = 8;
    localparam int APB_DW = 8;
endpackage

// File: rtl/apb_req_arbiter_rr.sv
// rr_arbiter: combinational round-robin one-hot pick; the search starts one
// past the last granted requester, which is remembered when en_i accepts a pick.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);
    logic [IW-1:0] last_q;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!any_o && req_i[(int'(last_q) + k) % N_REQ]) begin
                any_o = 1'b1;
                gnt_o[(int'(last_q) + k) % N_REQ] = 1'b1;
                idx_o = IW'((int'(last_q) + k) % N_REQ);
            end
        end
    end

    // Reset to the highest index so requester 0 wins the first search.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= IW'(N_REQ - 1);
        else if (en_i && any_o) last_q <= idx_o;
    end
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB slave between N_REQ requesters with
// round-robin arbitration, wait-state handling and an ACCESS timeout.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int A_WIDTH = APB_AW,
    parameter int D_WIDTH = APB_DW,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     p_clk,
    input  logic                     p_rstn,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_write,
    input  logic [N_REQ*A_WIDTH-1:0] req_addr,
    input  logic [N_REQ*D_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [D_WIDTH-1:0]       rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     p_sel,
    output logic                     p_enable,
    output logic                     p_write,
    output logic [A_WIDTH-1:0]       p_addr,
    output logic [D_WIDTH-1:0]       p_wdata,
    input  logic [D_WIDTH-1:0]       p_rdata,
    input  logic                     p_ready,
    input  logic                     p_slverr
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e         state_q, state_d;
    logic               write_q, write_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic [N_REQ-1:0]   owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [D_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [N_REQ-1:0]   pick;
    logic [IW-1:0]      pick_idx;
    logic               any_req, arb, done, expired, take;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk_i (p_clk),
        .rst_ni(p_rstn),
        .en_i  (arb),
        .req_i (req),
        .gnt_o (pick),
        .idx_o (pick_idx),
        .any_o (any_req)
    );

    // p_ready in the expiring cycle wins: the transfer completes normally.
    assign expired = (TIMEOUT > 0) && state_q == ACCESS && !p_ready && cnt_q >= CW'(TIMEOUT - 1);
    assign done    = state_q == ACCESS && (p_ready || expired);
    assign arb     = state_q == IDLE || done;
    assign take    = arb && any_req;
    assign gnt     = (arb && p_rstn) ? pick : '0;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cnt_d       = take ? '0 : (state_q == ACCESS && !done) ? cnt_q + 1'b1 : cnt_q;
        rsp_valid_d = done ? owner_q : '0;
        rsp_rdata_d = (done && p_ready && !write_q) ? p_rdata : '0;
        rsp_err_d   = done && (!p_ready || p_slverr);
        if (state_q == SETUP) state_d = ACCESS;
        else if (arb) state_d = any_req ? SETUP : IDLE;
        if (take) begin
            write_d = req_write[pick_idx];
            addr_d  = req_addr[pick_idx*A_WIDTH +: A_WIDTH];
            wdata_d = req_wdata[pick_idx*D_WIDTH +: D_WIDTH];
            owner_d = pick;
        end
    end

    always_ff @(posedge p_clk or negedge p_rstn) begin
        if (!p_rstn) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign p_sel     = state_q != IDLE;
    assign p_enable  = state_q == ACCESS;
    assign busy      = p_sel;
    assign p_write   = write_q;
    assign p_addr    = addr_q;
    assign p_wdata   = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: random requesters and a 16-entry APB memory slave,
// checked against a transfer-level timeline model of arbitration and responses.
module tb_apb_req_arbiter;
    import apb_pkg::*;
    localparam int AW = 8, DW = 8, N = 4, TO = 16;

    logic              p_clk = 1'b0, p_rstn;
    logic [N-1:0]      req, req_write, gnt, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_rdata, p_wdata, p_rdata;
    logic [AW-1:0]     p_addr;
    logic              rsp_err, busy, p_sel, p_enable, p_write, p_ready, p_slverr;

    always #5 p_clk = ~p_clk;

    apb_req_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .N_REQ(N), .TIMEOUT(TO)) dut (
        .p_clk(p_clk), .p_rstn(p_rstn), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .p_sel(p_sel),
        .p_enable(p_enable), .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ready(p_ready), .p_slverr(p_slverr)
    );

    typedef struct {bit w; bit [AW-1:0] a; bit [DW-1:0] d;} xfer_t;

    int         n_tests = 0, n_fail = 0;
    xfer_t      cur[N];
    bit         pend[N];
    bit [DW-1:0] mem[16];
    int         cyc, last, m_start, m_done, m_waits, m_owner, load;
    bit         m_busy, m_err_inj, found;
    xfer_t      m_x;
    bit [N-1:0] e_rv, only_mask;
    bit [DW-1:0] e_rd;
    bit         e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_psel"}, 32'(p_sel), 0);
        check({tag, "_penable"}, 32'(p_enable), 0);
        check({tag, "_paddr"}, 32'({p_write, p_addr, p_wdata}), 0);
    endtask

    task automatic model_reset();
        last = N - 1;
        m_busy = 0;
        e_rv = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
    endtask

    // One clock: drive at the falling edge, check 1 ns later, then advance the model.
    task automatic step();
        bit done, to;
        bit [N-1:0] eg;
        int win, r;
        @(negedge p_clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && only_mask[i] && $urandom_range(0, 99) < load) begin
                pend[i] = 1;
                cur[i] = '{w: 1'($urandom_range(0, 1)), a: AW'($urandom_range(0, 15)), d: DW'($urandom)};
            end
            req[i] = pend[i];
            req_write[i] = cur[i].w;
            req_addr[i*AW +: AW] = cur[i].a;
            req_wdata[i*DW +: DW] = cur[i].d;
        end
        done = m_busy && cyc == m_done;
        p_ready = m_busy && cyc == m_start + 2 + m_waits;
        p_slverr = p_ready ? m_err_inj : 1'($urandom_range(0, 1));
        p_rdata = p_ready ? mem[m_x.a[3:0]] : DW'($urandom);
        win = -1;
        if (!m_busy || done)
            for (int k = 1; k <= N; k++)
                if (win < 0 && pend[(last + k) % N]) win = (last + k) % N;
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        #1;
        check("gnt", 32'(gnt), 32'(eg));
        check("p_sel", 32'(p_sel), 32'(m_busy && cyc > m_start));
        check("p_enable", 32'(p_enable), 32'(m_busy && cyc >= m_start + 2));
        check("busy", 32'(busy), 32'(m_busy && cyc > m_start));
        if (m_busy && cyc > m_start) check("apb_fields", 32'({p_write, p_addr, p_wdata}), 32'({m_x.w, m_x.a, m_x.d}));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv != 0) begin
            check("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
            check("rsp_err", 32'(rsp_err), 32'(e_err));
        end
        e_rv = '0;
        if (done) begin
            to = m_waits >= TO;
            e_rv[m_owner] = 1'b1;
            e_err = to || m_err_inj;
            e_rd = (to || m_x.w) ? '0 : mem[m_x.a[3:0]];
            if (!to && m_x.w && !m_err_inj) mem[m_x.a[3:0]] = m_x.d;
            m_busy = 0;
        end
        if (win >= 0) begin
            m_busy = 1;
            m_start = cyc;
            m_owner = win;
            m_x = cur[win];
            pend[win] = 0;
            last = win;
            r = $urandom_range(0, 19);
            m_waits = r < 10 ? 0 : r < 16 ? r - 9 : r == 16 ? TO - 1 : r == 17 ? TO : TO + 5;
            m_done = cyc + 2 + (m_waits >= TO ? TO - 1 : m_waits);
            m_err_inj = $urandom_range(0, 4) == 0;
        end
        cyc++;
    endtask

    initial begin
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        p_rdata = '0; p_ready = 1'b0; p_slverr = 1'b0; p_rstn = 1'b0;
        cyc = 0;
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
        model_reset();
        @(negedge p_clk);
        req = '1;
        #1 check_zero("reset");
        @(negedge p_clk);
        req = '0;
        p_rstn = 1'b1;
        only_mask = '1; load = 100;
        repeat (60) step();
        only_mask = 4'b1010;
        repeat (40) step();
        only_mask = '1; load = 35;
        repeat (2000) step();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            found = m_busy && cyc >= m_start + 2;
        end
        check("reach_access", 32'(found), 1);
        @(negedge p_clk);
        p_ready = 1'b0;
        #1 check("enable_before_rst", 32'(p_enable), 1);
        p_rstn = 1'b0;
        #1 check_zero("rst_mid");
        repeat (2) begin
            @(negedge p_clk);
            #1 check("rst_hold_rsp_valid", 32'(rsp_valid), 0);
        end
        @(negedge p_clk);
        p_rstn = 1'b1;
        req = '0;
        cyc += 4;
        model_reset();
        only_mask = 4'b0100; load = 100;
        repeat (10) step();
        only_mask = '1; load = 50;
        repeat (300) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
